// File: rtl/div.sv
// rtl/div.sv - 16/8 unsigned restoring divider with IDLE/CALC/DONE control
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] dvd;        // dividend bits shift out the top, quotient bits shift in the bottom
  logic [7:0]  dvs;        // captured divisor
  logic [8:0]  prem;       // partial remainder
  logic [3:0]  count;      // step counter, wraps 15->0 on the last step
  logic [9:0]  shifted;
  logic        qbit;
  logic [8:0]  prem_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shifted   = {prem, dvd[15]};
    qbit      = (shifted >= {2'b00, dvs});
    prem_next = qbit ? (shifted[8:0] - {1'b0, dvs}) : shifted[8:0];
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = (B == 8'd0) ? DONE : CALC;
      CALC: if (count == 4'd15) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC);

  // State, datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      // done trails the DONE state by one edge so it is a clean registered pulse
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (enable) begin
            if (B == 8'd0) begin
              quotient  <= 16'hFFFF;
              remainder <= A[7:0];
              div_zero  <= 1'b1;
            end else begin
              dvd   <= A;
              dvs   <= B;
              prem  <= '0;
              count <= '0;
            end
          end
        end
        CALC: begin
          dvd   <= {dvd[14:0], qbit};
          prem  <= prem_next;
          count <= count + 4'd1;
          if (count == 4'd15) begin
            quotient  <= {dvd[14:0], qbit};
            remainder <= prem_next[7:0];
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 enable  input  1  start request; sampled only in IDLE.
REQ-005 A  input  16  unsigned dividend (same width as the 16-bit product bus).
REQ-006 B  input  8  unsigned divisor.
REQ-007 quotient  output  16  unsigned quotient, registered.
REQ-008 remainder  output  8  unsigned remainder, registered.
REQ-009 busy  output  1  high while in CALC.
REQ-010 done  output  1  one-cycle completion pulse, registered.
REQ-011 div_zero  output  1  high with done when B was 0; held with results.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, CALC and DONE.
REQ-013 In IDLE with enable=1 and B!=0, the edge SHALL:
- capture A and B;
- clear the partial remainder (9-bit working register) and the 4-bit iteration counter;
- go to CALC.
REQ-014 In IDLE with enable=1 and B=0, the edge SHALL:
- load quotient=16'hFFFF, remainder=A[7:0] and div_zero=1;
- go directly to DONE.
REQ-015 In CALC, each edge SHALL perform one restoring-division step:
- shift the partial remainder left, bringing in the next dividend bit (MSB first);
- if the result is >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
REQ-016 The subtraction SHALL use a 9-bit compare/subtract so that no carry is lost when the partial remainder is 8'hFF or below.
REQ-017 After the 16th CALC step (counter wraps 15->0), the same edge SHALL:
- load quotient and remainder;
- set div_zero=0;
- go to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-019 Normal latency: done is high in the cycle following the 17th rising edge after the edge that accepted enable. Divide-by-zero latency: 1 edge.
REQ-020 enable SHALL be ignored in CALC and DONE; operands are not re-captured and the running operation is not disturbed.
REQ-021 A and B changing during CALC SHALL NOT affect the result.
REQ-022 quotient, remainder and div_zero SHALL hold their values from the DONE edge until the next accepted enable.
- A new normal start does not update them until its own completion.
- A new divide-by-zero start updates them immediately.
REQ-023 busy SHALL be 1 exactly while in CALC, and 0 in IDLE and DONE.
REQ-024 The results SHALL satisfy A = quotient*B + remainder, with remainder < B, for all B != 0.
REQ-025 enable held high continuously SHALL start a new operation on each return to IDLE; back-to-back operations are separated by exactly one IDLE cycle.

Reset
REQ-026 reset=1 SHALL force IDLE and clear to 0 on that edge: quotient, remainder, busy, done, div_zero, counter and working registers.
REQ-027 reset SHALL take priority over enable and over any in-progress CALC/DONE activity.
REQ-028 A reset asserted mid-CALC SHALL abort the operation with no done pulse; the next enable after reset release starts a fresh operation.

Verification
REQ-029 Basic divide: A=16'h022B, B=8'h0F, enable pulse -> busy for 16 cycles; done after 17 edges; quotient=16'h0025, remainder=8'h00, div_zero=0.
REQ-030 Extremes: A=16'hFFFF, B=8'h01 -> quotient=16'hFFFF, remainder=0. A=16'hFFFF, B=8'hFF -> quotient=16'h0101, remainder=0. A=16'h0005, B=8'h07 -> quotient=0, remainder=5.
REQ-031 Divide by zero: A=16'h1234, B=0, enable -> done after 1 edge; quotient=16'hFFFF, remainder=8'h34, div_zero=1, busy never asserted.
REQ-032 Ignored start: enable re-pulsed with new A/B at CALC cycle 5 -> the original result is returned, and exactly one done pulse occurs.
REQ-033 Reset mid-op: reset at CALC cycle 8 -> the next edge shows all outputs 0 and state IDLE, with no done. A subsequent A=16'h0064, B=8'h0A yields quotient=16'h000A, remainder=0.
REQ-034 Random self-check: at least 1000 random A/B with B != 0, checked against REQ-024 and REQ-019 latency.
